sobel_edge_contour: RTL and testbench
=====================================

Name: sobel_edge_contour

Overview:
Upstream stage of anomaly_removal. It takes a raster-order 8-bit X-ray pixel stream and computes a 3x3 Sobel gradient magnitude per pixel, with zero padding at the image borders. It outputs each original pixel together with its thresholded edge-contour value, and both outputs stay cycle-aligned. The two outputs drive anomaly_removal's original_pixel and anomaly_pixel inputs directly.

Parameters:
IMG_WIDTH, 10, pixels per row (minimum 3).
IMG_HEIGHT, 10, rows per frame (minimum 3).
THRESHOLD, 8'd32, edge values below this are forced to 8'h00.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  pixel_in is valid this cycle.
in_ready  output  1  block accepts pixel_in when in_valid && in_ready.
pixel_in  input  8  raster-order input pixel.
out_valid  output  1  original_pixel/anomaly_pixel valid this cycle; there is no output backpressure.
original_pixel  output  8  centre pixel of the window, delayed to align with anomaly_pixel.
anomaly_pixel  output  8  saturated, thresholded Sobel magnitude.
frame_done  output  1  one-cycle pulse coincident with the last output of a frame.

Behaviour:
- Reset (asynchronous, any time): all outputs are 0 except in_ready, which is 1. Counters, line buffers and window are cleared, and the FSM goes to STREAM. A reset mid-frame discards the partial frame; the next accepted pixel is pixel (0,0).
- Storage: two line buffers of IMG_WIDTH x 8 bits, plus a 3x3 window register.
- Column counter wraps at IMG_WIDTH-1; row counter wraps at IMG_HEIGHT-1.
- FSM states:
  - STREAM: in_ready=1; window shifts only on an accepted input. Input gaps (in_valid=0) stall the pipeline and produce no output.
  - FLUSH: entered on the cycle after acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1). in_ready=0 for exactly IMG_WIDTH+1 cycles. Each cycle injects a zero pixel and shifts the window. Then the FSM returns to STREAM with counters at 0.
- Padding:
  - Neighbours left of column 0 or right of column IMG_WIDTH-1 are masked to 0, using the centre column index.
  - Neighbours above row 0 are 0; line-buffer contents from the previous frame are masked by the row index.
  - Neighbours below the last row are the FLUSH zeros.
- Arithmetic:
  - Gx = (right column: p[-1]+2p[0]+p[+1]) - (left column: same weights).
  - Gy = (bottom row) - (top row), with the same 1-2-1 weights.
  - Gx and Gy are 11-bit signed. mag = |Gx|+|Gy|, 12-bit unsigned.
  - sat = (mag > 255) ? 255 : mag[7:0].
  - anomaly_pixel = (sat < THRESHOLD) ? 0 : sat.
- Latency: the output for centre pixel k (raster index) has out_valid=1 exactly 2 cycles after the cycle in which input k+IMG_WIDTH+1 is accepted, or the equivalent FLUSH cycle. The 2 cycles are one register stage for the window and one for the magnitude.
- Output count and order: exactly IMG_WIDTH*IMG_HEIGHT outputs per frame, in raster order. frame_done rises with output index IMG_WIDTH*IMG_HEIGHT-1.
- Outputs hold their last value when out_valid=0.
- Back-to-back frames:
  - Pixels offered during FLUSH are not accepted (in_ready=0). The upstream source must hold them.
  - The first pixel accepted after FLUSH is (0,0) of the next frame.
  - Remaining frame-1 outputs may interleave in time with frame-2 input acceptance, and must stay correct.

Test Plan:
- Flat frame, all pixels 8'h80, THRESHOLD=1 -> all 36 border outputs are 8'hFF (corner mag 768, edge mag 512), all 64 interior outputs are 8'h00; original_pixel is 8'h80 on every output; exactly 100 out_valid pulses; frame_done on the 100th.
- Vertical step: columns 0-4 = 8'h00, columns 5-9 = 8'h40, THRESHOLD=8'h20 -> interior rows show 8'hFF at columns 4 and 5 (Gx=256) and 8'h00 at columns 1-3 and 6-8.
- Impulse: zero frame with 8'h10 at (5,5), THRESHOLD=0 -> 8'h20 at the eight neighbours of (5,5), 8'h00 elsewhere including (5,5). The same frame with THRESHOLD=8'h21 gives all outputs 8'h00.
- Random in_valid gaps (~30% idle) on the flat frame -> output values and order are identical to the gap-free run. in_ready drops for exactly 11 cycles after the 100th accepted pixel.
- Two back-to-back frames (flat 8'h80, then impulse) -> 200 outputs, each frame's values match its standalone run, and there is no top-row bleed from frame 1 into frame 2.
- Reset asserted after 47 pixels, then a full flat frame -> outputs are 0 during reset and in_ready=1; the following frame yields exactly 100 correct outputs.

Source files
------------

// File: rtl/sobel_edge_contour.sv
// Streaming 3x3 Sobel edge-contour stage: raster pixels in, centre pixel plus
// saturated and thresholded gradient magnitude out, zero-padded at the image borders.
module sobel_edge_contour #(
  parameter int         IMG_WIDTH  = 10,
  parameter int         IMG_HEIGHT = 10,
  parameter logic [7:0] THRESHOLD  = 8'd32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] pixel_in,
  output logic       out_valid,
  output logic [7:0] original_pixel,
  output logic [7:0] anomaly_pixel,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_PAD    = RW'(IMG_HEIGHT);
  localparam logic [RW-1:0] ROW_PAD2   = RW'(IMG_HEIGHT + 1);

  typedef enum logic [0:0] {STREAM = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state, next_state;
  logic [CW-1:0] col, fcnt, sc, cc, win_col;
  logic [RW-1:0] row, sr, cr, win_row;
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    lb2 [IMG_WIDTH];
  logic [7:0]    win [3][3];
  logic [7:0]    tap [3][3];
  logic [7:0]    new_pix, sat, edge_val;
  logic          accept, shift, c_valid, win_valid, win_last;
  logic [10:0]   lsum, rsum, tsum, bsum, gx, gy, ax, ay;
  logic [11:0]   mag;

  assign accept = in_valid && in_ready;
  assign shift  = accept || (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STREAM;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      STREAM:  next_state = (accept && col == COL_LAST && row == ROW_LAST) ? FLUSH : STREAM;
      FLUSH:   next_state = (fcnt == FLUSH_LAST) ? STREAM : FLUSH;
      default: next_state = STREAM;
    endcase
  end

  always_comb begin
    in_ready = (state == STREAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      fcnt <= '0;
    end else if (state == FLUSH) begin
      fcnt <= (fcnt == FLUSH_LAST) ? '0 : fcnt + CW'(1);
    end else if (accept) begin
      fcnt <= '0;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else begin
      fcnt <= '0;
    end
  end

  // Position of the incoming window column; flush columns sit on virtual rows below the frame.
  always_comb begin
    if (state == FLUSH) begin
      new_pix = 8'h00;
      sc      = (fcnt == FLUSH_LAST) ? '0 : fcnt;
      sr      = (fcnt == FLUSH_LAST) ? ROW_PAD2 : ROW_PAD;
    end else begin
      new_pix = pixel_in;
      sc      = col;
      sr      = row;
    end
    if (sc == '0) begin
      cc      = COL_LAST;
      cr      = sr - RW'(2);
      c_valid = (sr > RW'(1));
    end else begin
      cc      = sc - CW'(1);
      cr      = sr - RW'(1);
      c_valid = (sr != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb1[i] <= 8'h00;
        lb2[i] <= 8'h00;
      end
    end else if (shift) begin
      lb2[sc] <= lb1[sc];
      lb1[sc] <= new_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= 8'h00;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      win_valid <= shift && c_valid;
      if (shift) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2[sc];
        win[1][2] <= lb1[sc];
        win[2][2] <= new_pix;
        win_col   <= cc;
        win_row   <= cr;
        win_last  <= (cc == COL_LAST) && (cr == ROW_LAST);
      end
    end
  end

  // Taps outside the frame read as zero; stale line-buffer rows are hidden here too.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap[r][c] = ((c == 0 && win_col == '0) || (c == 2 && win_col == COL_LAST) ||
                     (r == 0 && win_row == '0) || (r == 2 && win_row == ROW_LAST))
                    ? 8'h00 : win[r][c];
      end
    end
    lsum = 11'(tap[0][0]) + 11'({tap[1][0], 1'b0}) + 11'(tap[2][0]);
    rsum = 11'(tap[0][2]) + 11'({tap[1][2], 1'b0}) + 11'(tap[2][2]);
    tsum = 11'(tap[0][0]) + 11'({tap[0][1], 1'b0}) + 11'(tap[0][2]);
    bsum = 11'(tap[2][0]) + 11'({tap[2][1], 1'b0}) + 11'(tap[2][2]);
    gx   = rsum - lsum;
    gy   = bsum - tsum;
    ax   = gx[10] ? (11'd0 - gx) : gx;
    ay   = gy[10] ? (11'd0 - gy) : gy;
    mag  = 12'(ax) + 12'(ay);
    sat  = (mag > 12'd255) ? 8'hFF : mag[7:0];
    edge_val = (sat < THRESHOLD) ? 8'h00 : sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      frame_done     <= 1'b0;
      original_pixel <= 8'h00;
      anomaly_pixel  <= 8'h00;
    end else begin
      out_valid  <= win_valid;
      frame_done <= win_valid && win_last;
      if (win_valid) begin
        original_pixel <= win[1][1];
        anomaly_pixel  <= edge_val;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_contour.sv
// Directed and randomized frame stimulus for sobel_edge_contour, scored against a
// plain 2D-convolution reference with per-output latency and in_ready expectations.
module tb_sobel_edge_contour;

  localparam int         W  = 10;
  localparam int         H  = 10;
  localparam logic [7:0] TH = 8'd32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] pixel_in = 8'h00;
  logic       out_valid;
  logic [7:0] original_pixel;
  logic [7:0] anomaly_pixel;
  logic       frame_done;

  sobel_edge_contour #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(TH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .original_pixel(original_pixel), .anomaly_pixel(anomaly_pixel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] orig;
    logic [7:0] anom;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t       expq[$];
  int         img [H][W];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         pix_idx = 0;
  int         flush_left = 0;
  int         n_out = 0;
  int         n_exp = 0;
  logic [7:0] hold_o = 8'h00;
  logic [7:0] hold_a = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int px(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r][c];
  endfunction

  function automatic logic [7:0] ref_edge(int r, int c);
    int gx, gy, mag, sat;
    gx  = (px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1)) - (px(r-1, c-1) + 2*px(r, c-1) + px(r+1, c-1));
    gy  = (px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1)) - (px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    sat = (mag > 255) ? 255 : mag;
    return (sat < int'(TH)) ? 8'h00 : 8'(sat);
  endfunction

  task automatic push(input int k, input int at);
    exp_t e;
    e.orig = 8'(img[k / W][k % W]);
    e.anom = ref_edge(k / W, k % W);
    e.done = (k == W*H - 1);
    e.cyc  = at;
    expq.push_back(e);
    n_exp++;
  endtask

  // Every out_valid pulse is matched in order against the reference; idle cycles must hold.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      if (out_valid === 1'b1) begin
        n_out++;
        if (expq.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("original_pixel", original_pixel, e.orig);
          chk("anomaly_pixel", anomaly_pixel, e.anom);
          chk("frame_done", frame_done, e.done);
          chk("latency_cycle", cyc, e.cyc);
          hold_o = e.orig;
          hold_a = e.anom;
        end
      end else begin
        chk("idle_frame_done", frame_done, 1'b0);
        chk("hold_original", original_pixel, hold_o);
        chk("hold_anomaly", anomaly_pixel, hold_a);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] p, output logic acc);
    logic exp_rdy;
    @(posedge clk); #1;
    in_valid = v;
    pixel_in = p;
    @(negedge clk);
    exp_rdy = (flush_left == 0);
    chk("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    if (flush_left > 0) flush_left--;
    if (acc) begin
      if (pix_idx >= W + 1) push(pix_idx - W - 1, cyc + 2);
      if (pix_idx == W*H - 1) begin
        for (int j = 0; j <= W; j++) push(W*H - W - 1 + j, cyc + 3 + j);
        flush_left = W + 1;
        pix_idx = 0;
      end else begin
        pix_idx++;
      end
    end
  endtask

  task automatic send_frame(input int n_pix, input int gap);
    int   sent = 0;
    int   guard = 0;
    logic acc;
    while (sent < n_pix && guard < 5000) begin
      step($urandom_range(0, 99) >= gap, 8'(img[sent / W][sent % W]), acc);
      if (acc) sent++;
      guard++;
    end
    if (sent < n_pix) chk("send_timeout", sent, n_pix);
  endtask

  task automatic drain();
    logic acc;
    int   guard = 0;
    while ((expq.size() != 0 || flush_left != 0) && guard < 300) begin
      step(1'b0, 8'h00, acc);
      guard++;
    end
    step(1'b0, 8'h00, acc);
    step(1'b0, 8'h00, acc);
    chk("drain_empty", expq.size(), 0);
  endtask

  task automatic fill(input int kind, input int val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = val;
          1: img[r][c] = (c >= 5) ? val : 0;
          2: img[r][c] = (r == 5 && c == 5) ? val : 0;
          default: img[r][c] = int'($urandom_range(0, val));
        endcase
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_original", original_pixel, 8'h00);
    chk("rst_anomaly", anomaly_pixel, 8'h00);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    fill(0, 8'h80); send_frame(W*H, 0);  drain();
    fill(1, 8'h40); send_frame(W*H, 0);  drain();
    fill(2, 8'h10); send_frame(W*H, 0);  drain();
    fill(2, 8'h0F); send_frame(W*H, 0);  drain();
    fill(0, 8'h80); send_frame(W*H, 30); drain();

    // back-to-back: next frame is offered while the previous one flushes
    fill(0, 8'h80); send_frame(W*H, 0);
    fill(2, 8'h10); send_frame(W*H, 0);
    fill(3, 255);   send_frame(W*H, 20);
    fill(3, 20);    send_frame(W*H, 30);
    drain();

    fill(0, 8'h80); send_frame(47, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    n_exp -= expq.size();
    expq.delete();
    pix_idx = 0;
    flush_left = 0;
    hold_o = 8'h00;
    hold_a = 8'h00;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    fill(0, 8'h80); send_frame(W*H, 0); drain();

    chk("output_count", n_out, n_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
